dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester controller in front of the byte-addressed 32-bit data memory.
- Port m0 is the core load/store unit; port m1 is the DMA/program loader.
- Arbitrates round-robin and sequences byte/half/word loads with sign or zero extension.
- Performs sub-word stores as read-modify-write, because the memory only accepts full 32-bit writes.

Parameters:
- ADDR_W, 32, width of request address and mem_A.
- DATA_W, 32, data width; fixed at 32, any other value is illegal.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- mN_req_valid  in  1  request valid (N = 0,1; m0 = core, m1 = DMA)
- mN_req_ready  out  1  request accepted this cycle
- mN_req_we  in  1  1 = store, 0 = load
- mN_req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mN_req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- mN_req_addr  in  ADDR_W  byte address
- mN_req_wdata  in  32  store data, right-aligned
- mN_rsp_valid  out  1  one-cycle completion pulse
- mN_rsp_rdata  out  32  extended load data; 0 for stores
- mem_A  out  ADDR_W  memory address
- mem_WD  out  32  memory write data
- mem_MemWrite  out  1  memory write strobe
- mem_RD  in  32  combinational memory read data: {mem[A+3],mem[A+2],mem[A+1],mem[A]}

Behaviour:
- Reset values: state IDLE; round-robin pointer favours m0; all ready/rsp_valid/rsp_rdata 0; mem_MemWrite 0; mem_A and mem_WD 0.
- mem_MemWrite is gated by !reset, so no write occurs in a reset cycle.
- Reset mid-operation drops the pending request; no write and no response are produced.
- State IDLE:
  - mN_req_ready is combinational and asserts only in IDLE, for the granted valid requester.
  - Grant rule: both valid -> grant the port not granted last; one valid -> grant it.
  - On acceptance, latch owner, we, size, unsigned, addr and wdata; update the pointer; go to EXEC.
- State EXEC: mem_A = latched addr.
  - Load: capture the extracted and extended mem_RD; go to RESP.
  - Word store: mem_WD = wdata, mem_MemWrite = 1; go to RESP.
  - Byte/half store: capture mem_RD into the merge register; go to MERGE.
- State MERGE:
  - mem_WD = {old[31:8], wdata[7:0]} for byte, {old[31:16], wdata[15:0]} for half.
  - mem_MemWrite = 1; go to RESP.
- State RESP: pulse the owner's rsp_valid for exactly one cycle with rsp_rdata; go to IDLE.
  - The response cannot be back-pressured.
  - Non-owner rsp_valid stays 0.
- Latency from the acceptance edge:
  - Load and word store: rsp_valid 2 cycles later.
  - Sub-word store: rsp_valid 3 cycles later.
  - Throughput is one request per 3 or 4 cycles.
- Load extraction:
  - Byte: RD[7:0] extended to 32 bits.
  - Half: RD[15:0] extended to 32 bits.
  - Word: RD unchanged.
- Requests arriving outside IDLE see ready = 0; a requester must hold valid and fields stable until ready.
- Address arithmetic wraps modulo 2^ADDR_W; memory bounds are not checked.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined:
  - Adds outputs mN_rsp_err (1 bit).
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, goes IDLE -> RESP directly.
  - It produces no memory write, rsp_err = 1 and rsp_rdata = 0.
  - rsp_err resets to 0.
- Undefined: no err ports; misaligned accesses proceed normally, since the byte memory supports them.

Decomposition:
- dmem_pkg holds:
  - typedef enum for size (SZ_B, SZ_H, SZ_W);
  - typedef enum for state (IDLE, EXEC, MERGE, RESP);
  - constants for port index (M_CORE = 0, M_DMA = 1).
- Sub-module dmem_lane_unit: purely combinational load extraction and store merge, shared by EXEC and MERGE.

Test Plan:
- m0 word store addr 0x10, wdata 0xDEADBEEF -> mem_MemWrite for 1 cycle at EXEC; m0_rsp_valid 2 cycles after accept; reading back 0x10 returns 0xDEADBEEF.
- Memory holds 0xDEADBEEF at 0x10; byte store 0x5A to 0x10 -> EXEC reads, MERGE writes 0xDEADBE5A; rsp_valid 3 cycles after accept.
- Loads from 0x10 holding 0x0000_80F0:
  - signed byte -> 0xFFFFFFF0;
  - unsigned half -> 0x000080F0;
  - signed half -> 0xFFFF80F0.
- m0 and m1 valid together, held for 3 requests each -> grant order m0, m1, m0, m1, m0, m1; the non-owner never sees rsp_valid.
- Assert reset during MERGE of a half store -> no mem_MemWrite, no rsp_valid; state IDLE next cycle; m0 favoured afterwards.
- With DMEM_ALIGN_CHECK_EN defined, word load at 0x13 -> rsp_valid 1 cycle after accept, rsp_err = 1, rdata = 0, no memory access; without the macro, the same load returns {mem[0x16..0x13]}.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dmem_pkg                                                   |
// | Brief   : Shared types and helpers for the data-memory arbiter:      |
// |           access size and FSM state encodings, requester indices.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package dmem_pkg;

    // Access size after decoding; the raw 2'b11 encoding folds onto SZ_W.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EXEC  = 2'b01,
        MERGE = 2'b10,
        RESP  = 2'b11
    } state_e;

    // Requester indices into per-port vectors.
    localparam int M_CORE = 0;
    localparam int M_DMA  = 1;

    // Map the raw request size field onto the access size.
    function automatic size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   decode_size = SZ_B;
            2'b01:   decode_size = SZ_H;
            default: decode_size = SZ_W;
        endcase
    endfunction

    // Half needs addr[0] clear, word needs addr[1:0] clear; bytes always fit.
    function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_H:    is_misaligned = lo[0];
            SZ_W:    is_misaligned = (lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dmem_lane_unit                                             |
// | Brief   : Combinational lane logic: extracts and sign/zero-extends   |
// |           load data, and merges sub-word store data into an old word.|
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  size_e       i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_rd,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    // Load extraction always takes the low lanes; the memory returns the
    // addressed byte in bits [7:0].
    always_comb begin
        o_load_data = i_rd;
        case (i_size)
            SZ_B: o_load_data = i_unsigned ? {24'd0, i_rd[7:0]}
                                           : {{24{i_rd[7]}}, i_rd[7:0]};
            SZ_H: o_load_data = i_unsigned ? {16'd0, i_rd[15:0]}
                                           : {{16{i_rd[15]}}, i_rd[15:0]};
            default: o_load_data = i_rd;
        endcase
    end

    // Store merge keeps the untouched upper bytes of the previously read word.
    always_comb begin
        o_merge_data = i_wdata;
        case (i_size)
            SZ_B:    o_merge_data = {i_rd[31:8],  i_wdata[7:0]};
            SZ_H:    o_merge_data = {i_rd[31:16], i_wdata[15:0]};
            default: o_merge_data = i_wdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : dmem_arbiter                                               |
// | Brief   : Two-port round-robin controller for a byte-addressed       |
// |           32-bit data memory. Sequences sign/zero-extended loads and |
// |           performs sub-word stores as read-modify-write.             |
// |           Optional macro DMEM_ALIGN_CHECK_EN adds mN_rsp_err and     |
// |           rejects misaligned half/word accesses.                     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_we,
    input  logic [1:0]        m0_req_size,
    input  logic              m0_req_unsigned,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [DATA_W-1:0] m0_req_wdata,
    output logic              m0_rsp_valid,
    output logic [DATA_W-1:0] m0_rsp_rdata,

    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_we,
    input  logic [1:0]        m1_req_size,
    input  logic              m1_req_unsigned,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [DATA_W-1:0] m1_req_wdata,
    output logic              m1_rsp_valid,
    output logic [DATA_W-1:0] m1_rsp_rdata,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic              m0_rsp_err,
    output logic              m1_rsp_err,
`endif

    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_MemWrite,
    input  logic [DATA_W-1:0] mem_RD
);

    if (DATA_W != 32) begin : g_data_w_check
        $error("dmem_arbiter: DATA_W must be 32");
    end

    state_e                     r_state;
    logic                       r_prio;     // port favoured when both request
    logic                       r_owner;
    logic                       r_we;
    size_e                      r_size;
    logic                       r_uns;
    logic [ADDR_W-1:0]          r_addr;
    logic [DATA_W-1:0]          r_wdata;
    logic [DATA_W-1:0]          r_old;      // word read back for a sub-word store
    logic [DATA_W-1:0]          r_rdata;
    logic [1:0]                 r_rsp_valid;
    logic [1:0][DATA_W-1:0]     r_rsp_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
    logic                       r_err;
    logic [1:0]                 r_rsp_err;
`endif

    logic                       w_any;
    logic                       w_gnt;
    logic                       w_we;
    logic [1:0]                 w_size_raw;
    logic                       w_uns;
    logic [ADDR_W-1:0]          w_addr;
    logic [DATA_W-1:0]          w_wdata;
    logic [DATA_W-1:0]          w_lane_rd;
    logic [DATA_W-1:0]          w_load;
    logic [DATA_W-1:0]          w_merge;
    logic                       w_word_store;

    // Round-robin grant and mux of the granted requester's fields.
    always_comb begin
        w_any = m0_req_valid | m1_req_valid;
        if (m0_req_valid && m1_req_valid) begin
            w_gnt = r_prio;
        end else begin
            w_gnt = m1_req_valid;
        end
        w_we       = w_gnt ? m1_req_we       : m0_req_we;
        w_size_raw = w_gnt ? m1_req_size     : m0_req_size;
        w_uns      = w_gnt ? m1_req_unsigned : m0_req_unsigned;
        w_addr     = w_gnt ? m1_req_addr     : m0_req_addr;
        w_wdata    = w_gnt ? m1_req_wdata    : m0_req_wdata;
    end

    assign m0_req_ready = (r_state == IDLE) && w_any && !w_gnt;
    assign m1_req_ready = (r_state == IDLE) && w_any &&  w_gnt;

    // In MERGE the lane unit works on the captured old word, otherwise on live read data.
    assign w_lane_rd    = (r_state == MERGE) ? r_old : mem_RD;
    assign w_word_store = r_we && (r_size == SZ_W);

    dmem_lane_unit u_lane (
        .i_size       (r_size),
        .i_unsigned   (r_uns),
        .i_rd         (w_lane_rd),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load),
        .o_merge_data (w_merge)
    );

    // Memory drive decoded from the current state; the write strobe is killed in reset.
    always_comb begin
        mem_A        = '0;
        mem_WD       = '0;
        mem_MemWrite = 1'b0;
        if (r_state == EXEC) begin
            mem_A = r_addr;
            if (w_word_store) begin
                mem_WD       = r_wdata;
                mem_MemWrite = !reset;
            end
        end else if (r_state == MERGE) begin
            mem_A        = r_addr;
            mem_WD       = w_merge;
            mem_MemWrite = !reset;
        end
    end

    // Request sequencer with registered responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_prio      <= 1'b0;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= SZ_B;
            r_uns       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_old       <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
            r_err       <= 1'b0;
            r_rsp_err   <= '0;
`endif
        end else begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
            r_rsp_err   <= '0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner <= w_gnt;
                        r_prio  <= ~w_gnt;
                        r_we    <= w_we;
                        r_size  <= decode_size(w_size_raw);
                        r_uns   <= w_uns;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_rdata <= '0;
`ifdef DMEM_ALIGN_CHECK_EN
                        if (is_misaligned(decode_size(w_size_raw), w_addr[1:0])) begin
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= EXEC;
                        end
`else
                        r_state <= EXEC;
`endif
                    end
                end
                EXEC: begin
                    if (!r_we) begin
                        r_rdata <= w_load;
                        r_state <= RESP;
                    end else if (w_word_store) begin
                        r_state <= RESP;
                    end else begin
                        r_old   <= mem_RD;
                        r_state <= MERGE;
                    end
                end
                MERGE: begin
                    r_state <= RESP;
                end
                RESP: begin
                    r_rsp_valid[r_owner] <= 1'b1;
                    r_rsp_rdata[r_owner] <= r_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
                    r_rsp_err[r_owner]   <= r_err;
`endif
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m0_rsp_valid = r_rsp_valid[M_CORE];
    assign m1_rsp_valid = r_rsp_valid[M_DMA];
    assign m0_rsp_rdata = r_rsp_rdata[M_CORE];
    assign m1_rsp_rdata = r_rsp_rdata[M_DMA];
`ifdef DMEM_ALIGN_CHECK_EN
    assign m0_rsp_err   = r_rsp_err[M_CORE];
    assign m1_rsp_err   = r_rsp_err[M_DMA];
`endif

endmodule
`default_nettype wire
